// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, drives the combinational imem read and loads IF/ID.
// Latency 1 clk fetch_addr->if_instr; stall holds PC and IF/ID, redirect/halt/fault squash IF/ID.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter logic [31:0] TEXT_LO  = 32'h0040_0000,
    parameter logic [31:0] TEXT_HI  = 32'h0080_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt_req,
    output logic [31:0] fetch_addr,
    input  logic [31:0] fetch_instr,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] fetch_count,
    output logic        fetch_fault,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_HALTED = 2'd1,
        S_FAULT  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_if_valid;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_pc_plus4;
    logic [31:0] r_fetch_count;
    logic        r_fetch_fault;
    logic        r_halted;

    logic        w_pc_legal;
    logic [31:0] w_pc_plus4;

    assign w_pc_legal = (r_pc[1:0] == 2'b00) && (r_pc >= TEXT_LO) && (r_pc <= TEXT_HI);
    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_RUN;
            r_pc          <= RESET_PC;
            r_if_valid    <= 1'b0;
            r_if_instr    <= 32'd0;
            r_if_pc       <= 32'd0;
            r_if_pc_plus4 <= 32'd0;
            r_fetch_count <= 32'd0;
            r_fetch_fault <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (halt_req) begin
                        r_state    <= S_HALTED;
                        r_halted   <= 1'b1;
                        r_if_valid <= 1'b0;
                        r_if_instr <= 32'd0;
                    end else if (redirect_valid) begin
                        // No delay slot: whatever sits at the old pc is squashed.
                        r_pc       <= redirect_target;
                        r_if_valid <= 1'b0;
                        r_if_instr <= 32'd0;
                    end else if (!w_pc_legal) begin
                        r_state       <= S_FAULT;
                        r_fetch_fault <= 1'b1;
                        r_if_valid    <= 1'b0;
                        r_if_instr    <= 32'd0;
                    end else if (!stall) begin
                        r_if_instr    <= fetch_instr;
                        r_if_pc       <= r_pc;
                        r_if_pc_plus4 <= w_pc_plus4;
                        r_if_valid    <= 1'b1;
                        r_fetch_count <= r_fetch_count + 32'd1;
                        r_pc          <= w_pc_plus4;
                    end
                end
                default: begin
                    r_if_valid <= 1'b0;
                    r_if_instr <= 32'd0;
                end
            endcase
        end
    end

    assign fetch_addr  = r_pc;
    assign if_valid    = r_if_valid;
    assign if_instr    = r_if_instr;
    assign if_pc       = r_if_pc;
    assign if_pc_plus4 = r_if_pc_plus4;
    assign fetch_count = r_fetch_count;
    assign fetch_fault = r_fetch_fault;
    assign halted      = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table for the corner sequences, then
// randomized traffic compared against a cycle-level behavioural model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] TEXT_LO  = 32'h0040_0000;
    localparam logic [31:0] TEXT_HI  = 32'h0080_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic        halt_req = 1'b0;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_instr;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] fetch_count;
    logic        fetch_fault;
    logic        halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC(RESET_PC),
        .TEXT_LO (TEXT_LO),
        .TEXT_HI (TEXT_HI)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .halt_req       (halt_req),
        .fetch_addr     (fetch_addr),
        .fetch_instr    (fetch_instr),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .fetch_count    (fetch_count),
        .fetch_fault    (fetch_fault),
        .halted         (halted)
    );

    // Instruction memory: a tiny program at the text base, address-derived words elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0040_0000: mem_word = 32'h2008_0005;
            32'h0040_0004: mem_word = 32'h0000_0000;
            32'h0040_0008: mem_word = 32'h2009_000A;
            32'h0040_000C: mem_word = 32'h0109_5020;
            default:       mem_word = {a[15:0], ~a[15:0]};
        endcase
    endfunction

    assign fetch_instr = mem_word(fetch_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, stl, rdv;
        logic [31:0] tgt;
        logic        hlt;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] instr, pc, pc4, cnt;
        logic        flt, hlo;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, stl, rdv, input logic [31:0] tgt, input logic hlt,
                       input logic [31:0] addr, input logic vld,
                       input logic [31:0] instr, pc, pc4, cnt, input logic flt, hlo);
        vec_t v;
        v.rst = rst; v.stl = stl; v.rdv = rdv; v.tgt = tgt; v.hlt = hlt;
        v.addr = addr; v.vld = vld; v.instr = instr; v.pc = pc; v.pc4 = pc4;
        v.cnt = cnt; v.flt = flt; v.hlo = hlo;
        vecs.push_back(v);
    endtask

    task automatic compare_all(input string tag, input logic [31:0] addr, input logic vld,
                               input logic [31:0] instr, pc, pc4, cnt, input logic flt, hlo);
        chk({tag, " fetch_addr"},  fetch_addr,  addr);
        chk({tag, " if_valid"},    {31'd0, if_valid},    {31'd0, vld});
        chk({tag, " if_instr"},    if_instr,    instr);
        chk({tag, " if_pc"},       if_pc,       pc);
        chk({tag, " if_pc_plus4"}, if_pc_plus4, pc4);
        chk({tag, " fetch_count"}, fetch_count, cnt);
        chk({tag, " fetch_fault"}, {31'd0, fetch_fault}, {31'd0, flt});
        chk({tag, " halted"},      {31'd0, halted},      {31'd0, hlo});
    endtask

    // Behavioural reference: stopped flags plus an IF/ID snapshot.
    logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4, m_cnt;
    logic        m_vld, m_halted, m_fault;

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (a >= TEXT_LO) && (a <= TEXT_HI);
    endfunction

    task automatic model_step(input logic rst, stl, rdv, input logic [31:0] tgt, input logic hlt);
        if (rst) begin
            m_pc = RESET_PC; m_vld = 0; m_instr = 0; m_ifpc = 0; m_ifpc4 = 0;
            m_cnt = 0; m_halted = 0; m_fault = 0;
        end else if (m_halted || m_fault) begin
            m_vld = 0; m_instr = 0;
        end else if (hlt) begin
            m_halted = 1; m_vld = 0; m_instr = 0;
        end else if (rdv) begin
            m_pc = tgt; m_vld = 0; m_instr = 0;
        end else if (!legal(m_pc)) begin
            m_fault = 1; m_vld = 0; m_instr = 0;
        end else if (!stl) begin
            m_instr = mem_word(m_pc);
            m_ifpc  = m_pc;
            m_ifpc4 = m_pc + 4;
            m_vld   = 1;
            m_cnt   = m_cnt + 1;
            m_pc    = m_pc + 4;
        end
    endtask

    initial begin
        logic [31:0] w0, w2, w3, m20, m800;
        w0 = 32'h2008_0005; w2 = 32'h2009_000A; w3 = 32'h0109_5020;
        m20 = mem_word(32'h0040_0020);
        m800 = mem_word(32'h0080_0000);

        // rst stl rdv tgt hlt | addr vld instr if_pc if_pc4 cnt flt hlt
        add(1,0,0,0,0, 32'h400000,0,0,0,0,0,0,0);
        add(0,0,0,0,0, 32'h400004,1,w0,32'h400000,32'h400004,1,0,0);
        add(0,0,0,0,0, 32'h400008,1,0, 32'h400004,32'h400008,2,0,0);
        add(0,1,0,0,0, 32'h400008,1,0, 32'h400004,32'h400008,2,0,0);
        add(0,1,0,0,0, 32'h400008,1,0, 32'h400004,32'h400008,2,0,0);
        add(0,0,0,0,0, 32'h40000C,1,w2,32'h400008,32'h40000C,3,0,0);
        add(0,0,0,0,0, 32'h400010,1,w3,32'h40000C,32'h400010,4,0,0);
        add(0,1,1,32'h400020,0, 32'h400020,0,0,32'h40000C,32'h400010,4,0,0);
        add(0,0,0,0,0, 32'h400024,1,m20,32'h400020,32'h400024,5,0,0);
        add(0,0,1,32'h400022,0, 32'h400022,0,0,32'h400020,32'h400024,5,0,0);
        add(0,0,0,0,0, 32'h400022,0,0,32'h400020,32'h400024,5,1,0);
        add(0,1,1,32'h400000,0, 32'h400022,0,0,32'h400020,32'h400024,5,1,0);
        add(0,0,0,0,1, 32'h400022,0,0,32'h400020,32'h400024,5,1,0);
        add(1,1,0,0,0, 32'h400000,0,0,0,0,0,0,0);
        add(0,0,0,0,0, 32'h400004,1,w0,32'h400000,32'h400004,1,0,0);
        add(0,0,0,0,0, 32'h400008,1,0, 32'h400004,32'h400008,2,0,0);
        add(0,0,0,0,0, 32'h40000C,1,w2,32'h400008,32'h40000C,3,0,0);
        add(0,0,0,0,0, 32'h400010,1,w3,32'h40000C,32'h400010,4,0,0);
        add(0,0,1,32'h400040,1, 32'h400010,0,0,32'h40000C,32'h400010,4,0,1);
        add(0,0,0,0,0, 32'h400010,0,0,32'h40000C,32'h400010,4,0,1);
        add(0,0,1,32'h400100,0, 32'h400010,0,0,32'h40000C,32'h400010,4,0,1);
        add(1,0,0,0,1, 32'h400000,0,0,0,0,0,0,0);
        add(0,0,1,32'h800000,0, 32'h800000,0,0,0,0,0,0,0);
        add(0,0,0,0,0, 32'h800004,1,m800,32'h800000,32'h800004,1,0,0);
        add(0,0,0,0,0, 32'h800004,0,0,32'h800000,32'h800004,1,1,0);
        add(1,0,0,0,0, 32'h400000,0,0,0,0,0,0,0);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst; stall = vecs[i].stl; redirect_valid = vecs[i].rdv;
            redirect_target = vecs[i].tgt; halt_req = vecs[i].hlt;
            @(posedge clk); #1;
            compare_all($sformatf("vec%0d", i), vecs[i].addr, vecs[i].vld, vecs[i].instr,
                        vecs[i].pc, vecs[i].pc4, vecs[i].cnt, vecs[i].flt, vecs[i].hlo);
        end

        // Randomized traffic against the model; first cycle forces reset to sync it.
        for (int c = 0; c < 3000; c++) begin
            logic        r_rst, r_stl, r_rdv, r_hlt;
            logic [31:0] r_tgt;
            r_rst = (c == 0) || ($urandom_range(0, 99) < 2);
            r_hlt = ($urandom_range(0, 199) == 0);
            r_rdv = ($urandom_range(0, 99) < 15);
            r_stl = ($urandom_range(0, 99) < 25);
            case ($urandom_range(0, 5))
                0, 1, 2: r_tgt = TEXT_LO + 4 * $urandom_range(0, 63);
                3:       r_tgt = TEXT_HI - 4 * $urandom_range(0, 2);
                4:       r_tgt = TEXT_LO + $urandom_range(0, 255);
                default: r_tgt = $urandom();
            endcase
            reset = r_rst; stall = r_stl; redirect_valid = r_rdv;
            redirect_target = r_tgt; halt_req = r_hlt;
            model_step(r_rst, r_stl, r_rdv, r_tgt, r_hlt);
            @(posedge clk); #1;
            compare_all($sformatf("rnd%0d", c), m_pc, m_vld, m_instr, m_ifpc, m_ifpc4,
                        m_cnt, m_fault, m_halted);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
